// File: rtl/xintf_dpbram_port_arbiter_if.sv
// Bus bundle between the two DPBRAM requesters, the port arbiter and the RAM port.
// The master modport is the requester/RAM side and the slave modport is the arbiter.
interface xintf_dpbram_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          en;
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_ce;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output en,
        output a_req, a_we, a_addr, a_din,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_din,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_addr, ram_ce, ram_we, ram_din,
        output ram_dout
    );

    modport slave (
        input  en,
        input  a_req, a_we, a_addr, a_din,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_din,
        output b_gnt, b_rvalid, b_rdata,
        output ram_addr, ram_ce, ram_we, ram_din,
        input  ram_dout
    );
endinterface

// File: rtl/xintf_dpbram_port_arbiter.sv
// Two-requester arbiter for one DPBRAM port: A (DSP XINTF) has priority, B (PL loader)
// is protected from starvation by a saturating wait counter. Read data returns in issue order.
module xintf_dpbram_port_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    xintf_dpbram_port_arbiter_if.slave    bus
);
    localparam logic [7:0] WAIT_MAX = 8'(STARVE_MAX);

    logic          a_gnt;
    logic          b_gnt;
    logic          any_gnt;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_din;
    logic          b_starved;

    logic [7:0]    wait_cnt_reg;
    logic [7:0]    wait_cnt_next;

    logic [AW-1:0] ram_addr_reg;
    logic          ram_ce_reg;
    logic          ram_we_reg;
    logic [DW-1:0] ram_din_reg;

    // Owner tag per in-flight read: valid bit plus "belongs to B" bit.
    logic [RD_LAT-1:0] tag_vld_reg;
    logic [RD_LAT-1:0] tag_b_reg;

    logic          a_rvalid_reg;
    logic [DW-1:0] a_rdata_reg;
    logic          b_rvalid_reg;
    logic [DW-1:0] b_rdata_reg;

    assign b_starved = bus.b_req && (wait_cnt_reg == WAIT_MAX);

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!i_rst && bus.en) begin
            if (bus.a_req && !b_starved) begin
                a_gnt = 1'b1;
            end else if (bus.b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign any_gnt  = a_gnt | b_gnt;
    assign win_we   = a_gnt ? bus.a_we   : bus.b_we;
    assign win_addr = a_gnt ? bus.a_addr : bus.b_addr;
    assign win_din  = a_gnt ? bus.a_din  : bus.b_din;

    // B pending but not granted while enabled means A took the slot.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (bus.en) begin
            if (!bus.b_req || b_gnt) begin
                wait_cnt_next = 8'd0;
            end else if (wait_cnt_reg < WAIT_MAX) begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt_reg   <= 8'd0;
            ram_ce_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_din_reg    <= '0;
            tag_vld_reg[0] <= 1'b0;
            tag_b_reg[0]   <= 1'b0;
        end else begin
            wait_cnt_reg   <= wait_cnt_next;
            ram_ce_reg     <= any_gnt;
            ram_we_reg     <= any_gnt & win_we;
            tag_vld_reg[0] <= any_gnt & ~win_we;
            tag_b_reg[0]   <= b_gnt;
            if (any_gnt) begin
                ram_addr_reg <= win_addr;
                ram_din_reg  <= win_din;
            end
        end
    end

    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_stage
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                tag_vld_reg[gi] <= 1'b0;
                tag_b_reg[gi]   <= 1'b0;
            end else begin
                tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                tag_b_reg[gi]   <= tag_b_reg[gi-1];
            end
        end
    end

    // i_ram_dout is captured RD_LAT-1 cycles after the ce cycle, so rvalid lands
    // RD_LAT+1 cycles after the grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
            a_rdata_reg  <= '0;
            b_rdata_reg  <= '0;
        end else begin
            a_rvalid_reg <= tag_vld_reg[RD_LAT-1] & ~tag_b_reg[RD_LAT-1];
            b_rvalid_reg <= tag_vld_reg[RD_LAT-1] &  tag_b_reg[RD_LAT-1];
            if (tag_vld_reg[RD_LAT-1] && !tag_b_reg[RD_LAT-1]) begin
                a_rdata_reg <= bus.ram_dout;
            end
            if (tag_vld_reg[RD_LAT-1] && tag_b_reg[RD_LAT-1]) begin
                b_rdata_reg <= bus.ram_dout;
            end
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.ram_addr = ram_addr_reg;
    assign bus.ram_ce   = ram_ce_reg;
    assign bus.ram_we   = ram_we_reg;
    assign bus.ram_din  = ram_din_reg;
    assign bus.a_rvalid = a_rvalid_reg;
    assign bus.a_rdata  = a_rdata_reg;
    assign bus.b_rvalid = b_rvalid_reg;
    assign bus.b_rdata  = b_rdata_reg;
endmodule

// File: tb/tb_xintf_dpbram_port_arbiter.sv
// Bench for the DPBRAM port arbiter: one DUT with RD_LAT=1 and one with RD_LAT=2 share the
// same stimulus; a cycle-level reference model predicts grants, RAM controls and read returns.
module tb_xintf_dpbram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int SM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    xintf_dpbram_port_arbiter_if #(.AW(AW), .DW(DW)) if1 ();
    xintf_dpbram_port_arbiter_if #(.AW(AW), .DW(DW)) if2 ();

    assign if1.en = en;       assign if2.en = en;
    assign if1.a_req = a_req; assign if2.a_req = a_req;
    assign if1.a_we = a_we;   assign if2.a_we = a_we;
    assign if1.a_addr = a_addr; assign if2.a_addr = a_addr;
    assign if1.a_din = a_din; assign if2.a_din = a_din;
    assign if1.b_req = b_req; assign if2.b_req = b_req;
    assign if1.b_we = b_we;   assign if2.b_we = b_we;
    assign if1.b_addr = b_addr; assign if2.b_addr = b_addr;
    assign if1.b_din = b_din; assign if2.b_din = b_din;

    xintf_dpbram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(SM)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1.slave));
    xintf_dpbram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .STARVE_MAX(SM)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(if2.slave));

    // RAM models: data for a ce in cycle c is presented on ram_dout in cycle c+RD_LAT-1.
    logic [DW-1:0] mem1 [2**AW];
    logic [DW-1:0] mem2 [2**AW];
    logic [DW-1:0] rd2_q;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    always @(posedge clk) begin
        if (load_en) begin
            mem1[load_addr] <= load_data;
            mem2[load_addr] <= load_data;
        end else begin
            if (if1.ram_ce && if1.ram_we) mem1[if1.ram_addr] <= if1.ram_din;
            if (if2.ram_ce && if2.ram_we) mem2[if2.ram_addr] <= if2.ram_din;
        end
        rd2_q <= mem2[if2.ram_addr];
    end
    assign if1.ram_dout = mem1[if1.ram_addr];
    assign if2.ram_dout = rd2_q;

    // Reference model state
    int            tests = 0;
    int            fails = 0;
    int unsigned   cyc = 0;
    int            wait_m;
    logic          ce_m, we_m;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] din_m;
    logic [DW-1:0] ref_mem [2**AW];
    int            lat [2] = '{1, 2};
    logic          sched_v [2][8];
    logic          sched_b [2][8];
    logic [DW-1:0] sched_d [2][8];
    logic          arv_m [2];
    logic          brv_m [2];
    logic [DW-1:0] ard_m [2];
    logic [DW-1:0] brd_m [2];
    logic          exp_a_gnt, exp_b_gnt;
    logic          obs_a_gnt, obs_b_gnt;

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_regs(input int d, input logic ce, input logic we, input logic [AW-1:0] ad,
                              input logic [DW-1:0] di, input logic arv, input logic [DW-1:0] ard,
                              input logic brv, input logic [DW-1:0] brd);
        check("ram_ce", d, ce, ce_m);
        check("ram_we", d, we, we_m);
        check("ram_addr", d, ad, addr_m);
        check("ram_din", d, di, din_m);
        check("a_rvalid", d, arv, arv_m[d-1]);
        check("a_rdata", d, ard, ard_m[d-1]);
        check("b_rvalid", d, brv, brv_m[d-1]);
        check("b_rdata", d, brd, brd_m[d-1]);
    endtask

    // One clock: inputs are already applied; check grants, advance model, check registered outputs.
    task automatic tick();
        logic ga, gb, w;
        logic [AW-1:0] ad;
        int slot;
        #1;
        ga = !rst && en && a_req && !(b_req && wait_m == SM);
        gb = !rst && en && b_req && !ga;
        obs_a_gnt = if1.a_gnt;
        obs_b_gnt = if1.b_gnt;
        check("a_gnt", 1, if1.a_gnt, ga);
        check("b_gnt", 1, if1.b_gnt, gb);
        check("a_gnt", 2, if2.a_gnt, ga);
        check("b_gnt", 2, if2.b_gnt, gb);
        exp_a_gnt = ga;
        exp_b_gnt = gb;
        if (rst) begin
            wait_m = 0; ce_m = 0; we_m = 0; addr_m = '0; din_m = '0;
            for (int k = 0; k < 2; k++) begin
                arv_m[k] = 0; brv_m[k] = 0; ard_m[k] = '0; brd_m[k] = '0;
                for (int s = 0; s < 8; s++) sched_v[k][s] = 0;
            end
        end else begin
            if (en) begin
                if (!b_req || gb) wait_m = 0;
                else if (wait_m < SM) wait_m++;
            end
            ce_m = ga || gb;
            if (ga || gb) begin
                w  = ga ? a_we : b_we;
                ad = ga ? a_addr : b_addr;
                we_m = w; addr_m = ad; din_m = ga ? a_din : b_din;
                if (w) ref_mem[ad] = din_m;
                else for (int k = 0; k < 2; k++) begin
                    slot = int'((cyc + 1 + lat[k]) % 8);
                    sched_v[k][slot] = 1; sched_b[k][slot] = gb; sched_d[k][slot] = ref_mem[ad];
                end
            end else begin
                we_m = 0;
            end
            for (int k = 0; k < 2; k++) begin
                slot = int'((cyc + 1) % 8);
                arv_m[k] = sched_v[k][slot] && !sched_b[k][slot];
                brv_m[k] = sched_v[k][slot] &&  sched_b[k][slot];
                if (arv_m[k]) ard_m[k] = sched_d[k][slot];
                if (brv_m[k]) brd_m[k] = sched_d[k][slot];
                sched_v[k][slot] = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        check_regs(1, if1.ram_ce, if1.ram_we, if1.ram_addr, if1.ram_din,
                   if1.a_rvalid, if1.a_rdata, if1.b_rvalid, if1.b_rdata);
        check_regs(2, if2.ram_ce, if2.ram_we, if2.ram_addr, if2.ram_din,
                   if2.a_rvalid, if2.a_rdata, if2.b_rvalid, if2.b_rdata);
        $display("[TB] cyc=%0d rst=%0b en=%0b a_req=%0b b_req=%0b gnt=%0b%0b ce=%0b", cyc, rst, en,
                 a_req, b_req, exp_a_gnt, exp_b_gnt, if1.ram_ce);
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di);
        a_req = req; a_we = we; a_addr = ad; a_din = di;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] di);
        b_req = req; b_we = we; b_addr = ad; b_din = di;
    endtask

    initial begin
        rst = 1; en = 1;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        load_en = 1; load_addr = '0; load_data = '0;
        for (int i = 0; i < 2**AW; i++) begin
            load_addr = AW'(i);
            load_data = (i == 5) ? 16'hA5A5 : DW'($urandom);
            ref_mem[i] = load_data;
            @(posedge clk);
            #1;
        end
        load_en = 0;

        // Reset state
        tick();
        check("rst_ce", 1, if1.ram_ce, 0);
        check("rst_rvalid", 2, if2.a_rvalid, 0);
        rst = 0;
        tick();

        // Lone A read of 0x005
        set_a(1, 0, 9'h005, '0);
        tick();
        check("t1_a_gnt", 1, obs_a_gnt, 1);
        check("t1_ce", 1, if1.ram_ce, 1);
        check("t1_addr", 1, if1.ram_addr, 9'h005);
        set_a(0, 0, '0, '0);
        tick();
        check("t1_rvalid", 1, if1.a_rvalid, 1);
        check("t1_rdata", 1, if1.a_rdata, 16'hA5A5);
        check("t1_b_idle", 1, if1.b_rvalid, 0);
        tick();

        // Lone B write 0x1FF <- 0x1234
        set_b(1, 1, 9'h1FF, 16'h1234);
        tick();
        check("t3_b_gnt", 1, obs_b_gnt, 1);
        check("t3_we", 1, if1.ram_we, 1);
        check("t3_din", 1, if1.ram_din, 16'h1234);
        set_b(0, 0, '0, '0);
        tick();
        tick();

        // Continuous contention: B first alone to start from wait=0, then A,A,A,A,B pattern
        set_b(1, 0, 9'h1FF, '0);
        tick();
        set_a(1, 0, 9'h005, '0);
        for (int i = 0; i < 12; i++) begin
            a_addr = AW'($urandom); b_addr = AW'($urandom);
            tick();
            check("t2_pattern_b", 1, obs_b_gnt, (i % 5 == 4) ? 1 : 0);
            check("t2_one_ce", 1, if1.ram_ce, 1);
        end

        // Enable low freezes counter (left at 2): after re-enable expect A,A,B
        en = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_no_ce", 1, if1.ram_ce, 0);
        end
        en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_a_gnt", 1, obs_a_gnt, (i < 2) ? 1 : 0);
        end
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        tick();
        tick();
        tick();

        // Reset one cycle after an A read grant drops the read
        set_a(1, 0, 9'h007, '0);
        tick();
        set_a(0, 0, '0, '0);
        rst = 1;
        tick();
        check("t5_ce_zero", 1, if1.ram_ce, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_rvalid", 1, if1.a_rvalid, 0);
            check("t5_no_rvalid", 2, if2.a_rvalid, 0);
        end
        set_a(1, 0, 9'h005, '0);
        tick();
        set_a(0, 0, '0, '0);
        tick();
        tick();

        // Interleaved reads: A 0x001, B 0x010, A 0x002, A 0x003
        set_a(1, 0, 9'h001, '0);
        tick();
        set_a(0, 0, '0, '0);
        set_b(1, 0, 9'h010, '0);
        tick();
        set_b(0, 0, '0, '0);
        set_a(1, 0, 9'h002, '0);
        tick();
        a_addr = 9'h003;
        tick();
        check("t6_b_rvalid", 2, if2.b_rvalid, 1);
        check("t6_b_rdata", 2, if2.b_rdata, ref_mem[16]);
        set_a(0, 0, '0, '0);
        for (int i = 0; i < 4; i++) tick();

        // Randomised traffic; requests hold until granted
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) < 90);
            if (!a_req || exp_a_gnt)
                set_a($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
            if (!b_req || exp_b_gnt)
                set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
            tick();
        end
        rst = 0;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
